// File: rtl/avg_pkg.sv
// Shared types and width helpers for the multi-lane packet averager.
package avg_pkg;

    typedef enum logic [1:0] {ACC, DIV, OUT} avg_state_t;

    // Count must hold the value max_len itself, hence the +1.
    function automatic int unsigned f_cnt_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int unsigned f_sum_w(input int unsigned bit_w, input int unsigned max_len);
        return bit_w + f_cnt_w(max_len);
    endfunction

endpackage

// File: rtl/avg_pkt_mc_if.sv
// Sample-in / average-out signal bundle for avg_pkt_mc.
interface avg_pkt_mc_if
    import avg_pkg::*;
#(
    parameter int unsigned G_BIT_WIDTH = 8,
    parameter int unsigned G_CH        = 1,
    parameter int unsigned G_MAX_LEN   = 256
);
    localparam int unsigned CW = f_cnt_w(G_MAX_LEN);

    logic [G_CH*G_BIT_WIDTH-1:0] i_data;
    logic                        i_valid;
    logic                        i_last;
    logic                        o_ready;
    logic [G_CH*G_BIT_WIDTH-1:0] o_avg_data;
    logic [CW-1:0]               o_cnt;
    logic                        o_ovf;
    logic                        o_valid;

    modport master (
        output i_data, i_valid, i_last,
        input  o_ready, o_avg_data, o_cnt, o_ovf, o_valid
    );

    modport slave (
        input  i_data, i_valid, i_last,
        output o_ready, o_avg_data, o_cnt, o_ovf, o_valid
    );

endinterface

// File: rtl/avg_div.sv
// Sequential restoring divider, one quotient bit per cycle over G_QUO_W cycles.
// Numerator bits above G_QUO_W preload the remainder; caller guarantees quotient < 2**G_QUO_W.
module avg_div #(
    parameter int unsigned G_NUM_W = 17,
    parameter int unsigned G_DEN_W = 9,
    parameter int unsigned G_QUO_W = G_NUM_W,
    parameter int unsigned G_OUT_W = G_QUO_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [G_NUM_W-1:0] i_num,
    input  logic [G_DEN_W-1:0] i_den,
    output logic [G_OUT_W-1:0] o_quo,
    output logic               o_done
);
    localparam int unsigned IW = $clog2(G_QUO_W + 1);

    logic [G_DEN_W-1:0] rem_q;
    logic [G_QUO_W-1:0] quo_q;
    logic [G_DEN_W-1:0] den_q;
    logic [IW-1:0]      iter_q;
    logic               busy_q;

    logic [G_DEN_W:0]   trial;
    logic [G_DEN_W-1:0] diff;
    logic               ge;

    // Partial remainder stays below den, so the low bits of the difference are exact.
    always_comb begin
        trial = {rem_q, quo_q[G_QUO_W-1]};
        ge    = (trial >= {1'b0, den_q});
        diff  = trial[G_DEN_W-1:0] - den_q;
    end

    assign o_done = busy_q && (iter_q == IW'(G_QUO_W));
    assign o_quo  = quo_q[G_OUT_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
        end else if (i_start) begin
            rem_q  <= G_DEN_W'(i_num >> G_QUO_W);
            quo_q  <= i_num[G_QUO_W-1:0];
            den_q  <= i_den;
            iter_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (o_done) begin
                busy_q <= 1'b0;
            end else begin
                rem_q  <= ge ? diff : trial[G_DEN_W-1:0];
                quo_q  <= {quo_q[G_QUO_W-2:0], ge};
                iter_q <= iter_q + IW'(1);
            end
        end
    end

endmodule

// File: rtl/avg_pkt_mc.sv
// Multi-lane packet averager: accumulate lanes until i_last, divide by count, strobe result.
// Build option: define AVG_ROUND_EN for round-half-up instead of truncation.
module avg_pkt_mc
    import avg_pkg::*;
#(
    parameter int unsigned G_BIT_WIDTH = 8,
    parameter int unsigned G_CH        = 1,
    parameter int unsigned G_MAX_LEN   = 256
) (
    input logic         i_clk,
    input logic         i_rst_n,
    avg_pkt_mc_if.slave bus
);
    localparam int unsigned BW = G_BIT_WIDTH;
    localparam int unsigned CW = f_cnt_w(G_MAX_LEN);
    localparam int unsigned SW = f_sum_w(G_BIT_WIDTH, G_MAX_LEN);
`ifdef AVG_ROUND_EN
    localparam int unsigned NW = SW + 1;
`else
    localparam int unsigned NW = SW;
`endif

    avg_state_t state_q, state_d;

    logic [SW-1:0] sum_q [G_CH];
    logic [SW-1:0] sum_d [G_CH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic [NW-1:0] num [G_CH];
    logic [BW-1:0] quo [G_CH];
    logic [G_CH-1:0] done_vec;
    logic            div_done;

    logic [G_CH*BW-1:0] avg_next;
    logic [G_CH*BW-1:0] avg_q;
    logic [CW-1:0]      cnt_out_q;
    logic               ovf_out_q;
    logic               valid_q;

    logic accept;
    logic start;

    assign bus.o_ready    = (state_q == ACC);
    assign accept         = bus.i_valid & bus.o_ready;
    assign start          = accept & bus.i_last;
    assign div_done       = &done_vec;
    assign bus.o_avg_data = avg_q;
    assign bus.o_cnt      = cnt_out_q;
    assign bus.o_ovf      = ovf_out_q;
    assign bus.o_valid    = valid_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACC:     if (start) state_d = DIV;
            DIV:     if (div_done) state_d = OUT;
            OUT:     state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // Samples beyond G_MAX_LEN are dropped so the sum can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        for (int k = 0; k < G_CH; k++) sum_d[k] = sum_q[k];
        if (state_q == OUT) begin
            cnt_d = '0;
            ovf_d = 1'b0;
            for (int k = 0; k < G_CH; k++) sum_d[k] = '0;
        end else if (accept) begin
            if (cnt_q < CW'(G_MAX_LEN)) begin
                cnt_d = cnt_q + CW'(1);
                for (int k = 0; k < G_CH; k++) begin
                    sum_d[k] = sum_q[k] + SW'(bus.i_data[k*BW +: BW]);
                end
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < G_CH; k++) begin : g_lane
`ifdef AVG_ROUND_EN
        assign num[k] = {1'b0, sum_d[k]} + NW'(cnt_d >> 1);
`else
        assign num[k] = sum_d[k];
`endif
        // Divider loads the post-accept sum/count on the same edge that takes i_last.
        avg_div #(
            .G_NUM_W (NW),
            .G_DEN_W (CW),
            .G_QUO_W (SW),
            .G_OUT_W (BW)
        ) u_div (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_start (start),
            .i_num   (num[k]),
            .i_den   (cnt_d),
            .o_quo   (quo[k]),
            .o_done  (done_vec[k])
        );
    end

    always_comb begin
        avg_next = '0;
        for (int k = 0; k < G_CH; k++) avg_next[k*BW +: BW] = quo[k];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ACC;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < G_CH; k++) sum_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < G_CH; k++) sum_q[k] <= sum_d[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            avg_q     <= '0;
            cnt_out_q <= '0;
            ovf_out_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (state_q == DIV && div_done) begin
                avg_q     <= avg_next;
                cnt_out_q <= cnt_q;
                ovf_out_q <= ovf_q;
                valid_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avg_pkt_mc.sv
// Bench for avg_pkt_mc: single-lane (max 256) and dual-lane (max 4) instances.
module tb_avg_pkt_mc;

`ifdef AVG_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    localparam int ML_A  = 256;
    localparam int ML_B  = 4;
    localparam int LAT_A = 8 + $clog2(ML_A + 1) + 1;
    localparam int LAT_B = 8 + $clog2(ML_B + 1) + 1;

    typedef struct {
        int sel;
        int base;
        int len;
        int exp0;
        int exp1;
        int expc;
        int expo;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    avg_pkt_mc_if #(.G_BIT_WIDTH(8), .G_CH(1), .G_MAX_LEN(ML_A)) bus_a ();
    avg_pkt_mc_if #(.G_BIT_WIDTH(8), .G_CH(2), .G_MAX_LEN(ML_B)) bus_b ();

    avg_pkt_mc #(.G_BIT_WIDTH(8), .G_CH(1), .G_MAX_LEN(ML_A)) u_dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_a)
    );

    avg_pkt_mc #(.G_BIT_WIDTH(8), .G_CH(2), .G_MAX_LEN(ML_B)) u_dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cur0[$];
    int cur1[$];
    int pool0[$];
    int pool1[$];
    vec_t vecs[$];
    int res_avg0, res_avg1, res_cnt, res_ovf, res_lat, res_ready, res_hold0, res_got;
    int exp0, exp1, expc, expo;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input bit v, input bit l, input int d0, input int d1);
        if (sel == 0) begin
            bus_a.i_valid = v;
            bus_a.i_last  = l;
            bus_a.i_data  = 8'(d0);
        end else begin
            bus_b.i_valid = v;
            bus_b.i_last  = l;
            bus_b.i_data  = {8'(d1), 8'(d0)};
        end
    endtask

    task automatic pad_lane1();
        while (cur1.size() < cur0.size()) cur1.push_back(0);
    endtask

    // Drive cur0/cur1 as one packet, then wait (bounded) for the result strobe.
    task automatic run_pkt(input int sel, input bit gaps, input bit hold);
        int n;
        bit vld;
        bit rdy;
        pad_lane1();
        n = cur0.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                drive(sel, 1'b0, 1'b0, 0, 0);
                @(negedge clk);
            end
            drive(sel, 1'b1, (i == n - 1), cur0[i], cur1[i]);
            @(negedge clk);
        end
        if (hold) drive(sel, 1'b1, 1'b0, 99, 99);
        else drive(sel, 1'b0, 1'b0, 0, 0);
        res_lat = 0;
        res_got = 0;
        res_ready = 0;
        while (res_got == 0 && res_lat < 100) begin
            @(negedge clk);
            res_lat++;
            vld = (sel == 0) ? bus_a.o_valid : bus_b.o_valid;
            rdy = (sel == 0) ? bus_a.o_ready : bus_b.o_ready;
            if (vld) res_got = 1;
            else if (rdy) res_ready = 1;
        end
        drive(sel, 1'b0, 1'b0, 0, 0);
        if (sel == 0) begin
            res_avg0 = int'(bus_a.o_avg_data);
            res_avg1 = 0;
            res_cnt  = int'(bus_a.o_cnt);
            res_ovf  = int'(bus_a.o_ovf);
        end else begin
            res_avg0 = int'(bus_b.o_avg_data[7:0]);
            res_avg1 = int'(bus_b.o_avg_data[15:8]);
            res_cnt  = int'(bus_b.o_cnt);
            res_ovf  = int'(bus_b.o_ovf);
        end
        @(negedge clk);
        res_hold0 = (sel == 0) ? int'(bus_a.o_avg_data) : int'(bus_b.o_avg_data[7:0]);
    endtask

    task automatic check_pkt(input string tag, input int sel, input int e0, input int e1,
                             input int ec, input int eo);
        check({tag, "_strobe"}, res_got, 1);
        check({tag, "_avg0"}, res_avg0, e0);
        if (sel == 1) check({tag, "_avg1"}, res_avg1, e1);
        check({tag, "_cnt"}, res_cnt, ec);
        check({tag, "_ovf"}, res_ovf, eo);
        check({tag, "_latency"}, res_lat, (sel == 0) ? LAT_A : LAT_B);
        check({tag, "_ready_low"}, res_ready, 0);
        check({tag, "_held"}, res_hold0, e0);
    endtask

    // Reference: plain arithmetic over the first min(n, max) samples.
    task automatic model(input int sel);
        int n, ml, s0, s1;
        n  = cur0.size();
        ml = (sel == 0) ? ML_A : ML_B;
        expc = (n > ml) ? ml : n;
        expo = (n > ml) ? 1 : 0;
        s0 = 0;
        s1 = 0;
        for (int i = 0; i < expc; i++) begin
            s0 += cur0[i];
            s1 += cur1[i];
        end
        exp0 = RND ? (s0 + expc / 2) / expc : s0 / expc;
        exp1 = RND ? (s1 + expc / 2) / expc : s1 / expc;
    endtask

    task automatic push(input int a, input int b);
        pool0.push_back(a);
        pool1.push_back(b);
    endtask

    task automatic add_vec(input int sel, input int base, input int e0, input int e1,
                           input int ec, input int eo);
        vec_t v;
        v.sel  = sel;
        v.base = base;
        v.len  = pool0.size() - base;
        v.exp0 = e0;
        v.exp1 = e1;
        v.expc = ec;
        v.expo = eo;
        vecs.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        bit seen;
        drive(0, 1'b0, 1'b0, 0, 0);
        drive(1, 1'b0, 1'b0, 0, 0);

        b = pool0.size();
        for (int i = 1; i <= 10; i++) push(i, 0);
        push(24, 0);
        add_vec(0, b, 7, 0, 11, 0);
        b = pool0.size();
        push(1, 0); push(2, 0);
        add_vec(0, b, RND ? 2 : 1, 0, 2, 0);
        b = pool0.size();
        push(255, 0);
        add_vec(0, b, 255, 0, 1, 0);
        b = pool0.size();
        push(4, 10); push(4, 20); push(4, 30); push(4, 40); push(100, 50); push(100, 60);
        add_vec(1, b, 4, 25, 4, 1);
        b = pool0.size();
        push(1, 200); push(2, 200); push(3, 200); push(4, 200);
        add_vec(1, b, RND ? 3 : 2, 200, 4, 0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_a", int'(bus_a.o_ready), 1);
        check("rst_ready_b", int'(bus_b.o_ready), 1);
        check("rst_valid_a", int'(bus_a.o_valid), 0);
        check("rst_avg_a", int'(bus_a.o_avg_data), 0);
        check("rst_cnt_a", int'(bus_a.o_cnt), 0);
        check("rst_ovf_a", int'(bus_a.o_ovf), 0);

        foreach (vecs[i]) begin
            cur0.delete();
            cur1.delete();
            for (int j = 0; j < vecs[i].len; j++) begin
                cur0.push_back(pool0[vecs[i].base + j]);
                cur1.push_back(pool1[vecs[i].base + j]);
            end
            run_pkt(vecs[i].sel, 1'b0, 1'b0);
            check_pkt($sformatf("vec%0d", i), vecs[i].sel, vecs[i].exp0, vecs[i].exp1,
                      vecs[i].expc, vecs[i].expo);
        end

        // Source keeps i_valid high through DIV/OUT; nothing extra may be counted.
        cur0 = '{10, 20, 30};
        cur1.delete();
        run_pkt(0, 1'b0, 1'b1);
        check_pkt("hold", 0, 20, 0, 3, 0);
        cur0 = '{7, 9};
        cur1.delete();
        run_pkt(0, 1'b0, 1'b0);
        check_pkt("after_hold", 0, 8, 0, 2, 0);

        // Reset while dividing: result must be lost and outputs cleared.
        drive(0, 1'b1, 1'b0, 50, 0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 60, 0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_avg", int'(bus_a.o_avg_data), 0);
        check("midrst_cnt", int'(bus_a.o_cnt), 0);
        check("midrst_valid", int'(bus_a.o_valid), 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus_a.o_valid) seen = 1'b1;
        end
        check("midrst_no_strobe", int'(seen), 0);
        check("midrst_avg_after", int'(bus_a.o_avg_data), 0);
        cur0 = '{5, 5, 5};
        cur1.delete();
        run_pkt(0, 1'b0, 1'b0);
        check_pkt("post_rst", 0, 5, 0, 3, 0);

        for (int p = 0; p < 25; p++) begin
            int n;
            cur0.delete();
            cur1.delete();
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) cur0.push_back($urandom_range(0, 255));
            model(0);
            run_pkt(0, 1'b1, 1'b0);
            check_pkt($sformatf("rand_a%0d", p), 0, exp0, exp1, expc, expo);
        end
        for (int p = 0; p < 15; p++) begin
            int n;
            cur0.delete();
            cur1.delete();
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                cur0.push_back($urandom_range(0, 255));
                cur1.push_back($urandom_range(0, 255));
            end
            model(1);
            run_pkt(1, 1'b1, 1'b0);
            check_pkt($sformatf("rand_b%0d", p), 1, exp0, exp1, expc, expo);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
